// File: rtl/power_peak_capture_pkg.sv
// Shared types and constants for the laser power peak-capture stage.
package power_peak_capture_pkg;

  localparam int ADC_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BLANK   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  function automatic logic [ADC_W-1:0] max_sample(input logic [ADC_W-1:0] a,
                                                  input logic [ADC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/power_peak_capture_if.sv
// ADC stream / pulse gate inputs and peak/CW results of the peak-capture stage.
interface power_peak_capture_if;
  import power_peak_capture_pkg::*;

  logic             laser_pulse;
  logic             adc_data_valid;
  logic [ADC_W-1:0] adc_data_value;
  logic             clear_peak;
  logic [ADC_W-1:0] peak_power_value;
  logic [ADC_W-1:0] cw_power_value;
  logic [ADC_W-1:0] adc_data_old_value;
  logic             peak_valid;
  logic             window_timeout;

  modport master (
    output laser_pulse, adc_data_valid, adc_data_value, clear_peak,
    input  peak_power_value, cw_power_value, adc_data_old_value, peak_valid, window_timeout
  );

  modport slave (
    input  laser_pulse, adc_data_valid, adc_data_value, clear_peak,
    output peak_power_value, cw_power_value, adc_data_old_value, peak_valid, window_timeout
  );

endinterface

// File: rtl/power_peak_capture_cw_block_averager.sv
// Block averager for between-pulse (CW) samples: sums 2**CW_AVG_LOG2 accepted
// samples and presents their truncated mean together with a one-cycle done flag.
// flush throws away a partially filled block.
module cw_block_averager
  import power_peak_capture_pkg::*;
#(
  parameter int CW_AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sample_valid,
  input  logic [ADC_W-1:0] sample,
  input  logic             enable,
  input  logic             flush,
  output logic [ADC_W-1:0] avg,
  output logic             done
);

  localparam int ACC_W = ADC_W + CW_AVG_LOG2;
  localparam int CNT_W = (CW_AVG_LOG2 > 0) ? CW_AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CW_AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] cnt;
  logic             take;

  assign take    = sample_valid & enable & ~flush;
  assign acc_sum = acc + ACC_W'(sample);
  assign done    = take && (cnt == CNT_LAST);
  assign avg     = ADC_W'(acc_sum >> CW_AVG_LOG2);

  // Accumulate accepted samples; restart on block completion or flush.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
      cnt <= '0;
    end else if (flush || done) begin
      acc <= '0;
      cnt <= '0;
    end else if (take) begin
      acc <= acc_sum;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/power_peak_capture.sv
// Peak capture for the laser power-limit checker: tracks the max ADC sample in
// each pulse window (after a settling blank), publishes it when the window
// closes, and keeps a block-averaged CW level between pulses.
module power_peak_capture
  import power_peak_capture_pkg::*;
#(
  parameter int BLANK_CYCLES = 8,
  parameter int MAX_WINDOW   = 4096,
  parameter int CW_AVG_LOG2  = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  power_peak_capture_if.slave  bus
);

  localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int WIN_W = (MAX_WINDOW > 1) ? $clog2(MAX_WINDOW) : 1;
  localparam logic [BLK_W-1:0] BLANK_LAST = BLK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(MAX_WINDOW - 1);
  localparam state_t START_STATE = (BLANK_CYCLES == 0) ? ST_CAPTURE : ST_BLANK;

  state_t           state, state_next;
  logic             pulse_d1;
  logic             rise, fall;
  logic [BLK_W-1:0] blank_cnt, blank_cnt_next;
  logic [WIN_W-1:0] win_cnt, win_cnt_next;
  logic [ADC_W-1:0] peak_acc, peak_acc_next;
  logic [ADC_W-1:0] sample_max;
  logic             publish;
  logic [ADC_W-1:0] publish_value;
  logic             set_timeout;
  logic [ADC_W-1:0] peak_reg, old_reg, cw_reg, cw_avg;
  logic             timeout_reg;
  logic             cw_done, cw_enable;

  assign rise       = bus.laser_pulse & ~pulse_d1;
  assign fall       = ~bus.laser_pulse & pulse_d1;
  assign sample_max = bus.adc_data_valid ? max_sample(peak_acc, bus.adc_data_value) : peak_acc;
  assign cw_enable  = (state == ST_IDLE) & ~pulse_d1;

  // State, edge-detect register and window bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      pulse_d1  <= 1'b0;
      blank_cnt <= '0;
      win_cnt   <= '0;
      peak_acc  <= '0;
    end else begin
      state     <= state_next;
      pulse_d1  <= bus.laser_pulse;
      blank_cnt <= blank_cnt_next;
      win_cnt   <= win_cnt_next;
      peak_acc  <= peak_acc_next;
    end
  end

  // Next state, counter updates and window-close (publish) decisions.
  always_comb begin
    state_next     = state;
    blank_cnt_next = blank_cnt;
    win_cnt_next   = win_cnt;
    peak_acc_next  = peak_acc;
    publish        = 1'b0;
    publish_value  = '0;
    set_timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          state_next     = START_STATE;
          blank_cnt_next = '0;
          win_cnt_next   = '0;
          peak_acc_next  = '0;
        end
      end
      ST_BLANK: begin
        if (fall) begin
          state_next    = ST_HOLD;
          publish       = 1'b1;
          publish_value = '0;
        end else if (blank_cnt == BLANK_LAST) begin
          state_next   = ST_CAPTURE;
          win_cnt_next = '0;
        end else begin
          blank_cnt_next = blank_cnt + 1'b1;
        end
      end
      ST_CAPTURE: begin
        peak_acc_next = sample_max;
        if (fall) begin
          state_next    = ST_HOLD;
          publish       = 1'b1;
          publish_value = sample_max;
        end else if (win_cnt == WIN_LAST) begin
          state_next    = ST_HOLD;
          publish       = 1'b1;
          publish_value = sample_max;
          set_timeout   = 1'b1;
        end else begin
          win_cnt_next = win_cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (rise) begin
          state_next     = START_STATE;
          blank_cnt_next = '0;
          win_cnt_next   = '0;
          peak_acc_next  = '0;
        end else if (bus.clear_peak) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Published results: peak on window close, sticky timeout, sample delay, CW level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      peak_reg    <= '0;
      timeout_reg <= 1'b0;
      old_reg     <= '0;
      cw_reg      <= '0;
    end else begin
      if (publish) peak_reg <= publish_value;
      if (set_timeout) timeout_reg <= 1'b1;
      else if (bus.clear_peak) timeout_reg <= 1'b0;
      if (bus.adc_data_valid) old_reg <= bus.adc_data_value;
      if (cw_done) cw_reg <= cw_avg;
    end
  end

  cw_block_averager #(
    .CW_AVG_LOG2 (CW_AVG_LOG2)
  ) u_cw_avg (
    .clk          (clk),
    .rstn         (rstn),
    .sample_valid (bus.adc_data_valid),
    .sample       (bus.adc_data_value),
    .enable       (cw_enable),
    .flush        (rise),
    .avg          (cw_avg),
    .done         (cw_done)
  );

  assign bus.peak_power_value   = peak_reg;
  assign bus.cw_power_value     = cw_reg;
  assign bus.adc_data_old_value = old_reg;
  assign bus.peak_valid         = (state == ST_HOLD);
  assign bus.window_timeout     = timeout_reg;

endmodule

// File: tb/tb_power_peak_capture.sv
// Directed bench for power_peak_capture: reset, peak capture, same-cycle
// publish, stuck-pulse timeout, CW averaging and HOLD rise/clear priority.
module tb_power_peak_capture;

  localparam int BLANK_CYCLES = 8;
  localparam int MAX_WINDOW   = 4096;
  localparam int CW_AVG_LOG2  = 4;

  logic clk;
  logic rstn;
  int   total_count;
  int   bad_count;
  int   n;

  power_peak_capture_if bus ();

  power_peak_capture #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .MAX_WINDOW   (MAX_WINDOW),
    .CW_AVG_LOG2  (CW_AVG_LOG2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge, return just after the rising edge.
  task automatic applyStimulus(input logic pulse, input logic valid,
                               input logic [15:0] value, input logic clr);
    @(negedge clk);
    bus.laser_pulse    = pulse;
    bus.adc_data_valid = valid;
    bus.adc_data_value = value;
    bus.clear_peak     = clr;
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_count++;
    if (observed !== expected) begin
      bad_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    total_count = 0;
    bad_count   = 0;
    rstn               = 1'b0;
    bus.laser_pulse    = 1'b0;
    bus.adc_data_valid = 1'b0;
    bus.adc_data_value = '0;
    bus.clear_peak     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_peak",    32'(bus.peak_power_value),   0);
    checkOutput("rst_cw",      32'(bus.cw_power_value),     0);
    checkOutput("rst_old",     32'(bus.adc_data_old_value), 0);
    checkOutput("rst_valid",   32'(bus.peak_valid),         0);
    checkOutput("rst_timeout", 32'(bus.window_timeout),     0);
    @(negedge clk);
    rstn = 1'b1;

    // Reset asserted mid-CAPTURE clears everything without a clock edge
    $display("[TB] reset mid-window");
    applyStimulus(1, 0, 0, 0);
    for (int c = 1; c <= 12; c++) applyStimulus(1, (c == 11), 16'd777, 0);
    checkOutput("t1_old_pre", 32'(bus.adc_data_old_value), 777);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t1_peak",  32'(bus.peak_power_value),   0);
    checkOutput("t1_old",   32'(bus.adc_data_old_value), 0);
    checkOutput("t1_valid", 32'(bus.peak_valid),         0);
    @(negedge clk);
    bus.laser_pulse    = 1'b0;
    bus.adc_data_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) applyStimulus(0, 0, 0, 0);
    checkOutput("t1_valid_after", 32'(bus.peak_valid),       0);
    checkOutput("t1_peak_after",  32'(bus.peak_power_value), 0);

    // 200-cycle pulse, big samples during blanking must be ignored
    $display("[TB] basic pulse");
    applyStimulus(1, 0, 0, 0);
    for (int c = 1; c < 200; c++) begin
      case (c)
        4, 8:    applyStimulus(1, 1, 16'd5000, 0);
        10:      applyStimulus(1, 1, 16'd100, 0);
        20:      applyStimulus(1, 1, 16'd900, 0);
        30:      applyStimulus(1, 1, 16'd300, 0);
        default: applyStimulus(1, 0, 16'd0, 0);
      endcase
    end
    checkOutput("t2_valid_pre", 32'(bus.peak_valid),       0);
    checkOutput("t2_peak_pre",  32'(bus.peak_power_value), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_peak",    32'(bus.peak_power_value),   900);
    checkOutput("t2_valid",   32'(bus.peak_valid),         1);
    checkOutput("t2_timeout", 32'(bus.window_timeout),     0);
    checkOutput("t2_old",     32'(bus.adc_data_old_value), 300);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t2_clr_valid", 32'(bus.peak_valid),       0);
    checkOutput("t2_clr_peak",  32'(bus.peak_power_value), 900);

    // Fall in the same cycle as a larger valid sample
    $display("[TB] fall with sample");
    applyStimulus(1, 0, 0, 0);
    for (int c = 1; c < 20; c++) applyStimulus(1, (c == 10), 16'd900, 0);
    applyStimulus(0, 1, 16'd1200, 0);
    checkOutput("t3_peak",  32'(bus.peak_power_value), 1200);
    checkOutput("t3_valid", 32'(bus.peak_valid),       1);

    // HOLD: rise beats clear_peak, then a fall during blanking publishes 0
    $display("[TB] hold rise vs clear");
    applyStimulus(1, 0, 0, 1);
    checkOutput("t6_valid", 32'(bus.peak_valid),       0);
    checkOutput("t6_peak",  32'(bus.peak_power_value), 1200);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t6_still_blank", 32'(bus.peak_valid), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t6_blank_fall_peak",  32'(bus.peak_power_value), 0);
    checkOutput("t6_blank_fall_valid", 32'(bus.peak_valid),       1);
    applyStimulus(0, 0, 0, 1);

    // Stuck pulse: forced close after MAX_WINDOW capture cycles
    $display("[TB] window timeout");
    n = 0;
    do begin
      applyStimulus(1, (n == 50), 16'd4321, 0);
      n++;
    end while (!bus.peak_valid && n < 5000);
    checkOutput("t4_close_cycle", 32'(n), 32'(MAX_WINDOW + BLANK_CYCLES + 1));
    checkOutput("t4_timeout", 32'(bus.window_timeout),   1);
    checkOutput("t4_peak",    32'(bus.peak_power_value), 4321);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t4_hold_stays", 32'(bus.peak_valid), 1);
    applyStimulus(1, 0, 0, 1);
    checkOutput("t4_clr_timeout", 32'(bus.window_timeout), 0);
    checkOutput("t4_clr_valid",   32'(bus.peak_valid),     0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t4_idle_valid", 32'(bus.peak_valid), 0);

    // CW block average, partial block discarded by a pulse
    $display("[TB] cw average");
    for (int i = 0; i < 15; i++) applyStimulus(0, 1, 16'(1000 + i), 0);
    checkOutput("t5_cw_partial", 32'(bus.cw_power_value), 0);
    applyStimulus(0, 1, 16'd1015, 0);
    checkOutput("t5_cw_block", 32'(bus.cw_power_value), 1007);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 16'd3000, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("t5_cw_after_rise", 32'(bus.cw_power_value), 1007);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) applyStimulus(0, 1, 16'd2000, 0);
    checkOutput("t5_cw_fresh", 32'(bus.cw_power_value),     2000);
    checkOutput("t5_old",      32'(bus.adc_data_old_value), 2000);

    $display("test done: total=%0d bad=%0d", total_count, bad_count);
    $finish;
  end

endmodule
